ss_rvc_dmem: RTL and testbench
==============================

Name: ss_rvc_dmem

Overview:
Single-port word-addressed data memory that sits directly downstream of the core's Q103H data-memory interface. It returns load data in Q104H with fixed one-cycle latency.
A secondary valid/ready port gives a loader/debug agent background access. The core always has priority, and the secondary port only uses cycles in which the core issues no access.

Parameters:
MEM_WORDS, 1024, number of 32-bit words (power of 2, ≥ 4)
XLEN, 32, data/address width

Ports:
QClk  in  1  clock, rising edge
RstQnnnH  in  1  reset, asynchronous, active-low
AddressDmQ103H  in  XLEN  core byte address; word index = Address[log2(MEM_WORDS)+1:2], bits [1:0] ignored
WrDataDmQ103H  in  XLEN  core store data
RdEnDmQ103H  in  1  core load request
WrEnDmQ103H  in  1  core store request
RdDataDmQ104H  out  XLEN  core load data, one cycle after RdEn
ErrDmQ104H  out  1  one-cycle pulse: core access in Q103H was out of range
ExtReqValid  in  1  secondary request valid
ExtReqReady  out  1  secondary request accepted this cycle when high together with Valid
ExtReqWr  in  1  1 = write, 0 = read
ExtReqAddr  in  XLEN  secondary byte address (same decoding as core)
ExtReqWrData  in  XLEN  secondary write data
ExtRspValid  out  1  response valid
ExtRspReady  in  1  response consumed
ExtRspData  out  XLEN  read data (0 for writes)
ExtRspErr  out  1  request was out of range

Behaviour:
- Reset (RstQnnnH=0, async): RdDataDmQ104H=0, ErrDmQ104H=0, ExtRspValid=0, ExtRspData=0, ExtRspErr=0.
  - Memory array contents are not reset and are retained across reset.
  - An in-flight secondary response is discarded.
- Range: an address is in range iff Address < MEM_WORDS*4.
- Core port, no handshake, never stalled:
  - RdEn=1 in cycle N: RdDataDmQ104H at N+1 = mem[idx] as it was before any write in cycle N (read-before-write).
  - RdEn=0: RdDataDmQ104H holds its previous value.
  - WrEn=1: mem[idx] ← WrData at the end of cycle N. A core read of that word in N+1 returns the new data.
  - RdEn and WrEn both 1, same cycle: the write is performed, and the read returns the old data.
  - Out of range: the write is dropped, the read returns 0, and ErrDmQ104H=1 in N+1 only.
- Secondary port, two-state FSM:
  - States: IDLE (no response held) and RSP (ExtRspValid=1).
  - slot_free = (state==IDLE) | ExtRspReady.
  - ExtReqReady = !(RdEnDmQ103H | WrEnDmQ103H) & slot_free. This is combinational, and the core enables take priority unconditionally.
  - Accept (Valid&Ready) in cycle N: perform the read/write in cycle N.
    - In N+1: state=RSP, ExtRspValid=1, ExtRspData = read data (or 0 for a write), ExtRspErr = out-of-range flag.
  - RSP with ExtRspReady=1 and no new accept: go to IDLE, ExtRspValid=0.
  - RSP with ExtRspReady=1 and a new accept in the same cycle: stay in RSP with the new data (back-to-back, one access per cycle).
  - RSP with ExtRspReady=0: hold the response stable, and ExtReqReady=0.
  - An out-of-range secondary write is dropped. An out-of-range secondary read returns data 0 with ExtRspErr=1.
- Ordering between ports:
  - Accesses are serialized by the cycle in which they occur.
  - A secondary write accepted in cycle N is visible to a core read in N+1 and later.
  - A core write in N is visible to a secondary read accepted in N+1 and later.
- ExtReqValid may be dropped before acceptance, and no state changes. ExtReq* are sampled only on acceptance.
- Inference: the memory array must infer a single-port synchronous RAM. The one port is muxed between core and secondary using the priority rule above.

Test Plan:
- Reset, then core write: WrEn at addr 0x10, data 0xDEADBEEF; next cycle RdEn at addr 0x10 → RdDataDmQ104H=0xDEADBEEF one cycle later, ErrDmQ104H=0.
- Simultaneous RdEn+WrEn at addr 0x20:
  - Setup: mem holds 0x11111111; write data 0x22222222.
  - Response: RdData=0x11111111.
  - Follow-up: a read of 0x20 in the next cycle returns 0x22222222.
- Out of range, MEM_WORDS=1024:
  - Core read at addr 0x1000 → RdData=0, ErrDmQ104H pulses for exactly 1 cycle.
  - Secondary write at 0x1000, then a read of word 0 → word 0 is unchanged, ExtRspErr=1 on the write response.
- Priority: hold ExtReqValid=1 (read of 0x40 = 0xCAFEF00D) while the core issues RdEn for 3 cycles.
  - While the core is active: ExtReqReady=0 for those 3 cycles.
  - Accept: happens in the first idle cycle.
  - Response: ExtRspValid next cycle with data 0xCAFEF00D.
- Backpressure and back-to-back:
  - Stimulus: issue secondary reads of 0x0, 0x4, 0x8 with ExtRspReady=0 for 2 cycles, then ExtRspReady=1 continuously.
  - While held: the first response stays stable and ExtReqReady=0.
  - Once released: the responses arrive in order, one per cycle, with no loss.
- Reset mid-operation:
  - Stimulus: assert RstQnnnH=0 while ExtRspValid=1.
  - Response: ExtRspValid=0 immediately (async).
  - After release: a core read returns the pre-reset contents of memory.

Source files
------------

// File: rtl/ss_rvc_dmem_if.sv
// Bus bundle for ss_rvc_dmem: the core's Q103H/Q104H data-memory port plus the
// secondary valid/ready request/response port used by a loader or debug agent.
interface ss_rvc_dmem_if #(
    parameter int XLEN = 32
);
    // Core data-memory port
    logic [XLEN-1:0] AddressDmQ103H;
    logic [XLEN-1:0] WrDataDmQ103H;
    logic            RdEnDmQ103H;
    logic            WrEnDmQ103H;
    logic [XLEN-1:0] RdDataDmQ104H;
    logic            ErrDmQ104H;

    // Secondary request channel
    logic            ExtReqValid;
    logic            ExtReqReady;
    logic            ExtReqWr;
    logic [XLEN-1:0] ExtReqAddr;
    logic [XLEN-1:0] ExtReqWrData;

    // Secondary response channel
    logic            ExtRspValid;
    logic            ExtRspReady;
    logic [XLEN-1:0] ExtRspData;
    logic            ExtRspErr;

    // Requesting side: the core and the secondary agent
    modport master (
        output AddressDmQ103H, WrDataDmQ103H, RdEnDmQ103H, WrEnDmQ103H,
        input  RdDataDmQ104H, ErrDmQ104H,
        output ExtReqValid, ExtReqWr, ExtReqAddr, ExtReqWrData,
        input  ExtReqReady,
        input  ExtRspValid, ExtRspData, ExtRspErr,
        output ExtRspReady
    );

    // Memory side
    modport slave (
        input  AddressDmQ103H, WrDataDmQ103H, RdEnDmQ103H, WrEnDmQ103H,
        output RdDataDmQ104H, ErrDmQ104H,
        input  ExtReqValid, ExtReqWr, ExtReqAddr, ExtReqWrData,
        output ExtReqReady,
        output ExtRspValid, ExtRspData, ExtRspErr,
        input  ExtRspReady
    );
endinterface

// File: rtl/ss_rvc_dmem.sv
// Single-port word-addressed data memory. The core owns the RAM port whenever it
// issues a load or store; the secondary valid/ready port is granted only in
// cycles with no core access. Load data returns one cycle later; registered
// output values are held between reads so the RAM output register can be shared.
module ss_rvc_dmem #(
    parameter int MEM_WORDS = 1024,
    parameter int XLEN      = 32
) (
    input logic          QClk,
    input logic          RstQnnnH,
    ss_rvc_dmem_if.slave bus
);
    localparam int              AW         = $clog2(MEM_WORDS);
    localparam logic [XLEN-1:0] ADDR_LIMIT = XLEN'(MEM_WORDS) << 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RSP  = 1'b1
    } state_t;

    // RAM storage (no reset: contents survive reset)
    logic [XLEN-1:0] mem [MEM_WORDS];
    logic [XLEN-1:0] ram_rdata_q;

    // RAM port controls
    logic            ram_re;
    logic            ram_we;
    logic [AW-1:0]   ram_idx;
    logic [XLEN-1:0] ram_wdata;

    // Address decode
    logic            core_act;
    logic            core_in_range;
    logic [AW-1:0]   core_idx;
    logic            ext_in_range;
    logic [AW-1:0]   ext_idx;

    // Secondary handshake
    state_t          state_q, state_d;
    logic            slot_free;
    logic            ext_req_ready;
    logic            ext_accept;

    // Core return path
    logic            core_ld_q, core_ld_d;
    logic            core_ld_ok_q, core_ld_ok_d;
    logic [XLEN-1:0] rd_hold_q, rd_hold_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] rd_data;

    // Secondary return path
    logic            ext_fresh_q, ext_fresh_d;
    logic            ext_fresh_rd_q, ext_fresh_rd_d;
    logic [XLEN-1:0] ext_hold_q, ext_hold_d;
    logic            ext_err_q, ext_err_d;
    logic [XLEN-1:0] ext_data;

    // Decode both addresses and arbitrate the single RAM port (core first)
    always_comb begin
        core_act      = bus.RdEnDmQ103H | bus.WrEnDmQ103H;
        core_in_range = bus.AddressDmQ103H < ADDR_LIMIT;
        core_idx      = bus.AddressDmQ103H[AW+1:2];
        ext_in_range  = bus.ExtReqAddr < ADDR_LIMIT;
        ext_idx       = bus.ExtReqAddr[AW+1:2];

        slot_free     = (state_q == ST_IDLE) | bus.ExtRspReady;
        ext_req_ready = ~core_act & slot_free;
        ext_accept    = bus.ExtReqValid & ext_req_ready;

        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_idx   = core_idx;
        ram_wdata = bus.WrDataDmQ103H;
        if (core_act) begin
            ram_re = bus.RdEnDmQ103H & core_in_range;
            ram_we = bus.WrEnDmQ103H & core_in_range;
        end else if (ext_accept) begin
            ram_idx   = ext_idx;
            ram_wdata = bus.ExtReqWrData;
            ram_re    = ~bus.ExtReqWr & ext_in_range;
            ram_we    = bus.ExtReqWr & ext_in_range;
        end
    end

    // Synchronous single-port RAM, read-before-write on the same word
    always_ff @(posedge QClk) begin
        if (ram_re) begin
            ram_rdata_q <= mem[ram_idx];
        end
        if (ram_we) begin
            mem[ram_idx] <= ram_wdata;
        end
    end

    // Core response selection: fresh RAM data, zero for out-of-range, else hold
    always_comb begin
        if (core_ld_q) begin
            rd_data = core_ld_ok_q ? ram_rdata_q : '0;
        end else begin
            rd_data = rd_hold_q;
        end
        core_ld_d    = bus.RdEnDmQ103H;
        core_ld_ok_d = core_in_range;
        rd_hold_d    = rd_data;
        err_d        = core_act & ~core_in_range;
    end

    // Secondary response selection and next-state logic
    always_comb begin
        if (ext_fresh_q) begin
            ext_data = ext_fresh_rd_q ? ram_rdata_q : '0;
        end else begin
            ext_data = ext_hold_q;
        end
        ext_hold_d     = ext_data;
        ext_fresh_d    = ext_accept;
        ext_fresh_rd_d = ext_accept & ~bus.ExtReqWr & ext_in_range;
        ext_err_d      = ext_accept ? ~ext_in_range : ext_err_q;

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ext_accept) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (ext_accept) begin
                    state_d = ST_RSP;
                end else if (bus.ExtRspReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output-hold registers, cleared asynchronously
    always_ff @(posedge QClk or negedge RstQnnnH) begin
        if (!RstQnnnH) begin
            state_q        <= ST_IDLE;
            core_ld_q      <= 1'b0;
            core_ld_ok_q   <= 1'b0;
            rd_hold_q      <= '0;
            err_q          <= 1'b0;
            ext_fresh_q    <= 1'b0;
            ext_fresh_rd_q <= 1'b0;
            ext_hold_q     <= '0;
            ext_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            core_ld_q      <= core_ld_d;
            core_ld_ok_q   <= core_ld_ok_d;
            rd_hold_q      <= rd_hold_d;
            err_q          <= err_d;
            ext_fresh_q    <= ext_fresh_d;
            ext_fresh_rd_q <= ext_fresh_rd_d;
            ext_hold_q     <= ext_hold_d;
            ext_err_q      <= ext_err_d;
        end
    end

    assign bus.RdDataDmQ104H = rd_data;
    assign bus.ErrDmQ104H    = err_q;
    assign bus.ExtReqReady   = ext_req_ready;
    assign bus.ExtRspValid   = (state_q == ST_RSP);
    assign bus.ExtRspData    = ext_data;
    assign bus.ExtRspErr     = ext_err_q;

endmodule

// File: tb/tb_ss_rvc_dmem.sv
// Directed bench for ss_rvc_dmem: core load/store timing, read-before-write,
// out-of-range handling, core priority over the secondary port, response
// backpressure and asynchronous reset with memory retention.
module tb_ss_rvc_dmem;
    logic QClk;
    logic RstQnnnH;
    int   checks;
    int   errors;

    ss_rvc_dmem_if #(.XLEN(32)) bus ();

    ss_rvc_dmem #(.MEM_WORDS(1024), .XLEN(32)) dut (
        .QClk     (QClk),
        .RstQnnnH (RstQnnnH),
        .bus      (bus)
    );

    initial QClk = 1'b0;
    always #5 QClk = ~QClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge QClk);
        #1;
    endtask

    task automatic core_idle();
        bus.RdEnDmQ103H = 1'b0;
        bus.WrEnDmQ103H = 1'b0;
    endtask

    task automatic core_wr(input logic [31:0] a, input logic [31:0] d);
        bus.AddressDmQ103H = a;
        bus.WrDataDmQ103H  = d;
        bus.WrEnDmQ103H    = 1'b1;
        bus.RdEnDmQ103H    = 1'b0;
        step();
        core_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RstQnnnH = 1'b0;
        bus.AddressDmQ103H = '0;
        bus.WrDataDmQ103H  = '0;
        bus.RdEnDmQ103H    = 1'b0;
        bus.WrEnDmQ103H    = 1'b0;
        bus.ExtReqValid    = 1'b0;
        bus.ExtReqWr       = 1'b0;
        bus.ExtReqAddr     = '0;
        bus.ExtReqWrData   = '0;
        bus.ExtRspReady    = 1'b1;

        // Reset values
        step();
        step();
        chk("rst_rddata", bus.RdDataDmQ104H, 32'h0);
        chk("rst_err", {31'b0, bus.ErrDmQ104H}, 32'h0);
        chk("rst_rspvalid", {31'b0, bus.ExtRspValid}, 32'h0);
        chk("rst_rspdata", bus.ExtRspData, 32'h0);
        chk("rst_rsperr", {31'b0, bus.ExtRspErr}, 32'h0);
        RstQnnnH = 1'b1;
        step();

        // Core write then read-back
        core_wr(32'h10, 32'hDEADBEEF);
        bus.AddressDmQ103H = 32'h10;
        bus.RdEnDmQ103H    = 1'b1;
        step();
        core_idle();
        chk("wr_rd_data", bus.RdDataDmQ104H, 32'hDEADBEEF);
        chk("wr_rd_err", {31'b0, bus.ErrDmQ104H}, 32'h0);

        // Simultaneous read and write: old data returned, new data stored
        core_wr(32'h20, 32'h11111111);
        bus.AddressDmQ103H = 32'h20;
        bus.WrDataDmQ103H  = 32'h22222222;
        bus.RdEnDmQ103H    = 1'b1;
        bus.WrEnDmQ103H    = 1'b1;
        step();
        bus.WrEnDmQ103H = 1'b0;
        chk("rbw_old", bus.RdDataDmQ104H, 32'h11111111);
        step();
        core_idle();
        chk("rbw_new", bus.RdDataDmQ104H, 32'h22222222);
        step();
        chk("rd_hold", bus.RdDataDmQ104H, 32'h22222222);

        // Core out-of-range read
        bus.AddressDmQ103H = 32'h1000;
        bus.RdEnDmQ103H    = 1'b1;
        step();
        core_idle();
        chk("oor_rddata", bus.RdDataDmQ104H, 32'h0);
        chk("oor_err_pulse", {31'b0, bus.ErrDmQ104H}, 32'h1);
        step();
        chk("oor_err_clear", {31'b0, bus.ErrDmQ104H}, 32'h0);

        // Seed words used by the secondary tests
        core_wr(32'h0, 32'h00000A00);
        core_wr(32'h4, 32'h00000A04);
        core_wr(32'h8, 32'h00000A08);
        core_wr(32'h40, 32'hCAFEF00D);

        // Secondary out-of-range write must not alias onto word 0
        bus.ExtReqValid  = 1'b1;
        bus.ExtReqWr     = 1'b1;
        bus.ExtReqAddr   = 32'h1000;
        bus.ExtReqWrData = 32'hFFFFFFFF;
        #1;
        chk("ext_rdy_idle", {31'b0, bus.ExtReqReady}, 32'h1);
        step();
        bus.ExtReqWr   = 1'b0;
        bus.ExtReqAddr = 32'h0;
        chk("ext_oorw_valid", {31'b0, bus.ExtRspValid}, 32'h1);
        chk("ext_oorw_err", {31'b0, bus.ExtRspErr}, 32'h1);
        chk("ext_oorw_data", bus.ExtRspData, 32'h0);
        step();
        bus.ExtReqValid = 1'b0;
        chk("ext_w0_data", bus.ExtRspData, 32'h00000A00);
        chk("ext_w0_err", {31'b0, bus.ExtRspErr}, 32'h0);
        step();
        chk("ext_idle", {31'b0, bus.ExtRspValid}, 32'h0);

        // Core priority: secondary read of 0x40 blocked for 3 core cycles
        bus.ExtReqValid    = 1'b1;
        bus.ExtReqWr       = 1'b0;
        bus.ExtReqAddr     = 32'h40;
        bus.AddressDmQ103H = 32'h10;
        bus.RdEnDmQ103H    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("prio_rdy%0d", i), {31'b0, bus.ExtReqReady}, 32'h0);
            step();
            chk($sformatf("prio_rspv%0d", i), {31'b0, bus.ExtRspValid}, 32'h0);
        end
        core_idle();
        chk("prio_core_data", bus.RdDataDmQ104H, 32'hDEADBEEF);
        #1;
        chk("prio_rdy_free", {31'b0, bus.ExtReqReady}, 32'h1);
        step();
        bus.ExtReqValid = 1'b0;
        chk("prio_rspv", {31'b0, bus.ExtRspValid}, 32'h1);
        chk("prio_rspdata", bus.ExtRspData, 32'hCAFEF00D);
        step();
        chk("prio_idle", {31'b0, bus.ExtRspValid}, 32'h0);

        // Backpressure then back-to-back reads of 0x0, 0x4, 0x8
        bus.ExtRspReady = 1'b0;
        bus.ExtReqValid = 1'b1;
        bus.ExtReqAddr  = 32'h0;
        step();
        bus.ExtReqAddr = 32'h4;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("bp_rdy%0d", i), {31'b0, bus.ExtReqReady}, 32'h0);
            chk($sformatf("bp_valid%0d", i), {31'b0, bus.ExtRspValid}, 32'h1);
            chk($sformatf("bp_data%0d", i), bus.ExtRspData, 32'h00000A00);
            step();
        end
        bus.ExtRspReady = 1'b1;
        #1;
        chk("b2b_rdy", {31'b0, bus.ExtReqReady}, 32'h1);
        step();
        bus.ExtReqAddr = 32'h8;
        chk("b2b_valid1", {31'b0, bus.ExtRspValid}, 32'h1);
        chk("b2b_data1", bus.ExtRspData, 32'h00000A04);
        step();
        bus.ExtReqValid = 1'b0;
        chk("b2b_valid2", {31'b0, bus.ExtRspValid}, 32'h1);
        chk("b2b_data2", bus.ExtRspData, 32'h00000A08);
        step();
        chk("b2b_idle", {31'b0, bus.ExtRspValid}, 32'h0);

        // Asynchronous reset while a response is held
        bus.ExtRspReady = 1'b0;
        bus.ExtReqValid = 1'b1;
        bus.ExtReqAddr  = 32'h10;
        step();
        bus.ExtReqValid = 1'b0;
        chk("arst_pre_valid", {31'b0, bus.ExtRspValid}, 32'h1);
        chk("arst_pre_data", bus.ExtRspData, 32'hDEADBEEF);
        #2;
        RstQnnnH = 1'b0;
        #1;
        chk("arst_valid", {31'b0, bus.ExtRspValid}, 32'h0);
        chk("arst_data", bus.ExtRspData, 32'h0);
        chk("arst_rddata", bus.RdDataDmQ104H, 32'h0);
        step();
        RstQnnnH = 1'b1;
        bus.ExtRspReady    = 1'b1;
        bus.AddressDmQ103H = 32'h10;
        bus.RdEnDmQ103H    = 1'b1;
        step();
        core_idle();
        chk("arst_retain", bus.RdDataDmQ104H, 32'hDEADBEEF);
        chk("arst_rsp_idle", {31'b0, bus.ExtRspValid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
